// File: rtl/issue_if.sv
// Fetch-side channel of the issue stage: instruction handshake plus the
// registered redirect that steers fetch after a taken branch.
interface issue_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    modport master (
        output in_valid, in_instr, in_pc,
        input  in_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc,
        output in_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/issue_stage.sv
// Register-read / issue stage in front of the m1-m2-ex ALU pipe: holds one
// fetched instruction, reads operands, stalls on multiply hazards, flushes on branches.
module issue_stage (
    input  logic        clk,
    input  logic        rst,
    issue_if.slave      fetch,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [15:0] wb_data,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] rs1_data,
    output logic [15:0] rs2_data
);
    localparam logic [15:0] NOP = 16'h0000;

    logic             h_valid_r;
    logic [15:0]      h_instr_r;
    logic [15:0]      h_pc_r;
    logic [1:0]       mt_valid_r;
    logic [1:0][3:0]  mt_rd_r;
    logic [15:0]      rf_r [16];
    logic             redirect_valid_r;
    logic [15:0]      redirect_pc_r;

    logic [3:0]       rd_s;
    logic [3:0]       rs1_s;
    logic [3:0]       rs2_s;
    logic             illegal_s;
    logic             is_mul_s;
    logic             bubble_s;
    logic             hazard_s;
    logic             fire_s;
    logic             consume_s;
    logic             in_ready_s;
    logic [15:0]      rs1_val_s;
    logic [15:0]      rs2_val_s;

    // A tracked multiply destination collides with any register H touches.
    function automatic logic trk_hit(input logic v, input logic [3:0] trk,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c);
        return v && (trk != 4'd0) && ((trk == a) || (trk == b) || (trk == c));
    endfunction

    // Field decode of the held instruction; unused fields decode to r0.
    always_comb begin
        rd_s      = 4'd0;
        rs1_s     = 4'd0;
        rs2_s     = 4'd0;
        illegal_s = 1'b0;
        is_mul_s  = (h_instr_r[15:12] == 4'h5);
        case (h_instr_r[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                rd_s  = h_instr_r[11:8];
                rs1_s = h_instr_r[7:4];
                rs2_s = h_instr_r[3:0];
            end
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF: begin
                rd_s  = h_instr_r[11:8];
                rs1_s = h_instr_r[3:0];
            end
            4'hD: begin
                rs1_s = h_instr_r[11:8];
                rs2_s = h_instr_r[3:0];
            end
            4'hE: begin
                rd_s = 4'hF;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Issue control: bubble, hazard, fire and the fetch handshake.
    always_comb begin
        bubble_s   = mt_valid_r[1];
        hazard_s   = trk_hit(mt_valid_r[0], mt_rd_r[0], rs1_s, rs2_s, rd_s) |
                     trk_hit(mt_valid_r[1], mt_rd_r[1], rs1_s, rs2_s, rd_s);
        // A flush discards H in the same cycle, so it must not reach the ALU.
        fire_s     = h_valid_r & ~bubble_s & ~hazard_s & ~illegal_s & ~br_taken;
        consume_s  = fire_s | (h_valid_r & illegal_s);
        in_ready_s = (~h_valid_r | consume_s) & ~redirect_valid_r & ~br_taken;
    end

    // Operand read with write-through bypass from writeback.
    always_comb begin
        rs1_val_s = 16'h0000;
        rs2_val_s = 16'h0000;
        if (rs1_s == 4'd0) begin
            rs1_val_s = 16'h0000;
        end else if (wb_en && (wb_rd == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_r[rs1_s];
        end
        if (rs2_s == 4'd0) begin
            rs2_val_s = 16'h0000;
        end else if (wb_en && (wb_rd == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_r[rs2_s];
        end
    end

    // ALU-facing outputs: the held instruction when it fires, otherwise a bubble.
    always_comb begin
        instr    = NOP;
        pc       = 16'h0000;
        rs1_data = 16'h0000;
        rs2_data = 16'h0000;
        if (fire_s) begin
            instr    = h_instr_r;
            pc       = h_pc_r;
            rs1_data = rs1_val_s;
            rs2_data = rs2_val_s;
        end else begin
            instr    = NOP;
            pc       = 16'h0000;
            rs1_data = 16'h0000;
            rs2_data = 16'h0000;
        end
    end

    // Holding register, multiply tracker and one-cycle redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid_r        <= 1'b0;
            h_instr_r        <= NOP;
            h_pc_r           <= 16'h0000;
            mt_valid_r       <= 2'b00;
            mt_rd_r          <= '0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 16'h0000;
        end else begin
            if (br_taken) begin
                h_valid_r <= 1'b0;
            end else if (fetch.in_valid && in_ready_s) begin
                h_valid_r <= 1'b1;
                h_instr_r <= fetch.in_instr;
                h_pc_r    <= fetch.in_pc;
            end else if (consume_s) begin
                h_valid_r <= 1'b0;
            end
            // Older multiplies keep shifting through a flush.
            mt_valid_r[0]    <= fire_s & is_mul_s;
            mt_rd_r[0]       <= rd_s;
            mt_valid_r[1]    <= mt_valid_r[0];
            mt_rd_r[1]       <= mt_rd_r[0];
            redirect_valid_r <= br_taken;
            redirect_pc_r    <= br_taken ? br_target : 16'h0000;
        end
    end

    // Register file; r0 is never written and reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_r[i] <= 16'h0000;
            end
        end else if (wb_en && (wb_rd != 4'd0)) begin
            rf_r[wb_rd] <= wb_data;
        end
    end

    assign fetch.in_ready       = in_ready_s;
    assign fetch.redirect_valid = redirect_valid_r;
    assign fetch.redirect_pc    = redirect_pc_r;
endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: expected issues are queued as stimulus is
// driven and compared whenever a non-NOP instruction reaches the ALU outputs.
module tb_issue_stage;
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    issue_if fif ();

    issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fif),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Fetch input for this cycle; writeback and branch default to idle.
    task automatic drv(input logic v, input logic [15:0] ins, input logic [15:0] p);
        fif.in_valid = v;
        fif.in_instr = ins;
        fif.in_pc    = p;
        wb_en        = 1'b0;
        wb_rd        = 4'd0;
        wb_data      = 16'h0000;
        br_taken     = 1'b0;
        br_target    = 16'h0000;
    endtask

    task automatic wb(input logic [3:0] rd, input logic [15:0] d);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = d;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] p,
                        input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.a     = a;
        e.b     = b;
        sb_q.push_back(e);
    endtask

    // Every issued instruction must match the oldest expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (instr !== 16'h0000) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", {16'h0000, instr}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_instr", {16'h0000, instr}, {16'h0000, e.instr});
                check_eq("sb_pc", {16'h0000, pc}, {16'h0000, e.pc});
                check_eq("sb_rs1", {16'h0000, rs1_data}, {16'h0000, e.a});
                check_eq("sb_rs2", {16'h0000, rs2_data}, {16'h0000, e.b});
            end
        end
    end

    initial begin
        drv(1'b0, 16'h0000, 16'h0000);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_instr", {16'h0, instr}, 32'h0);
        check_eq("rst_pc", {16'h0, pc}, 32'h0);
        check_eq("rst_rs1", {16'h0, rs1_data}, 32'h0);
        check_eq("rst_rs2", {16'h0, rs2_data}, 32'h0);
        check_eq("rst_rv", {31'h0, fif.redirect_valid}, 32'h0);
        check_eq("rst_rpc", {16'h0, fif.redirect_pc}, 32'h0);
        nxt(); rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'h0, fif.in_ready}, 32'h1);

        // Basic issue, back-to-back acceptance, writeback bypass
        nxt(); drv(1'b0, 16'h0000, 16'h0000); wb(4'd1, 16'd5);
        nxt(); drv(1'b0, 16'h0000, 16'h0000); wb(4'd2, 16'd7);
        nxt(); drv(1'b1, 16'h0312, 16'h0010); push(16'h0312, 16'h0010, 16'd5, 16'd7);
        @(negedge clk); check_eq("t1_ready", {31'h0, fif.in_ready}, 32'h1);
        nxt(); drv(1'b1, 16'h0433, 16'h0012); push(16'h0433, 16'h0012, 16'd12, 16'd12);
        @(negedge clk); check_eq("t1_issue", {16'h0, instr}, 32'h0312);
        nxt(); drv(1'b0, 16'h0000, 16'h0000); wb(4'd3, 16'd12);
        @(negedge clk); check_eq("t1_bypass", {16'h0, rs1_data}, 32'd12);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);

        // Multiply followed by a RAW dependent
        nxt(); drv(1'b1, 16'h5312, 16'h0020); push(16'h5312, 16'h0020, 16'd5, 16'd7);
        nxt(); drv(1'b1, 16'h0430, 16'h0022); push(16'h0430, 16'h0022, 16'd35, 16'd0);
        @(negedge clk); check_eq("t2_mul", {16'h0, instr}, 32'h5312);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t2_stall", {16'h0, instr}, 32'h0);
        check_eq("t2_stall_rdy", {31'h0, fif.in_ready}, 32'h0);
        nxt(); drv(1'b0, 16'h0000, 16'h0000); wb(4'd3, 16'd35);
        @(negedge clk); check_eq("t2_bubble", {16'h0, instr}, 32'h0);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t2_dep", {16'h0, instr}, 32'h0430);
        check_eq("t2_dep_rs1", {16'h0, rs1_data}, 32'd35);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);

        // Multiply followed by independent instructions
        nxt(); drv(1'b1, 16'h5712, 16'h0030); push(16'h5712, 16'h0030, 16'd5, 16'd7);
        nxt(); drv(1'b1, 16'h0512, 16'h0032); push(16'h0512, 16'h0032, 16'd5, 16'd7);
        @(negedge clk); check_eq("t3_mul", {16'h0, instr}, 32'h5712);
        nxt(); drv(1'b1, 16'h6612, 16'h0034); push(16'h6612, 16'h0034, 16'd7, 16'd0);
        @(negedge clk); check_eq("t3_indep", {16'h0, instr}, 32'h0512);
        nxt(); drv(1'b0, 16'h0000, 16'h0000); wb(4'd7, 16'd35);
        @(negedge clk); check_eq("t3_bubble", {16'h0, instr}, 32'h0);
        check_eq("t3_bubble_rdy", {31'h0, fif.in_ready}, 32'h0);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t3_next", {16'h0, instr}, 32'h6612);

        // Back-to-back multiplies give two bubbles
        nxt(); drv(1'b1, 16'h5812, 16'h0040); push(16'h5812, 16'h0040, 16'd5, 16'd7);
        nxt(); drv(1'b1, 16'h5912, 16'h0042); push(16'h5912, 16'h0042, 16'd5, 16'd7);
        nxt(); drv(1'b1, 16'h0512, 16'h0044); push(16'h0512, 16'h0044, 16'd5, 16'd7);
        @(negedge clk); check_eq("t4_mul2", {16'h0, instr}, 32'h5912);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t4_bub1", {16'h0, instr}, 32'h0);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t4_bub2", {16'h0, instr}, 32'h0);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t4_after", {16'h0, instr}, 32'h0512);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);

        // Taken branch flushes H and redirects fetch
        nxt(); drv(1'b1, 16'h0312, 16'h0050);
        nxt(); drv(1'b1, 16'h0433, 16'h0052); br_taken = 1'b1; br_target = 16'h0040;
        @(negedge clk); check_eq("t5_flush_instr", {16'h0, instr}, 32'h0);
        check_eq("t5_flush_rdy", {31'h0, fif.in_ready}, 32'h0);
        nxt(); drv(1'b1, 16'h0433, 16'h0040);
        @(negedge clk); check_eq("t5_rv", {31'h0, fif.redirect_valid}, 32'h1);
        check_eq("t5_rpc", {16'h0, fif.redirect_pc}, 32'h0040);
        check_eq("t5_redir_rdy", {31'h0, fif.in_ready}, 32'h0);
        check_eq("t5_redir_instr", {16'h0, instr}, 32'h0);
        nxt(); drv(1'b1, 16'h0433, 16'h0040); push(16'h0433, 16'h0040, 16'd35, 16'd35);
        @(negedge clk); check_eq("t5_rdy_back", {31'h0, fif.in_ready}, 32'h1);
        check_eq("t5_rv_drop", {31'h0, fif.redirect_valid}, 32'h0);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t5_target", {16'h0, instr}, 32'h0433);

        // Illegal instruction is consumed silently
        nxt(); drv(1'b1, 16'hB123, 16'h0060);
        nxt(); drv(1'b1, 16'h0512, 16'h0062); push(16'h0512, 16'h0062, 16'd5, 16'd7);
        @(negedge clk); check_eq("t6_ill_instr", {16'h0, instr}, 32'h0);
        check_eq("t6_ill_rdy", {31'h0, fif.in_ready}, 32'h1);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t6_next", {16'h0, instr}, 32'h0512);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);

        // Reset pulse one cycle after a multiply issue
        nxt(); drv(1'b1, 16'h5312, 16'h0070); push(16'h5312, 16'h0070, 16'd5, 16'd7);
        nxt(); drv(1'b1, 16'h0430, 16'h0072);
        @(negedge clk); check_eq("t7_mul", {16'h0, instr}, 32'h5312);
        nxt(); drv(1'b0, 16'h0000, 16'h0000); rst = 1'b1;
        #2;
        check_eq("t7_rst_instr", {16'h0, instr}, 32'h0);
        check_eq("t7_rst_pc", {16'h0, pc}, 32'h0);
        check_eq("t7_rst_rs1", {16'h0, rs1_data}, 32'h0);
        check_eq("t7_rst_rv", {31'h0, fif.redirect_valid}, 32'h0);
        #1 rst = 1'b0;
        drv(1'b1, 16'h0430, 16'h0074); push(16'h0430, 16'h0074, 16'd0, 16'd0);
        @(negedge clk); check_eq("t7_rdy", {31'h0, fif.in_ready}, 32'h1);
        nxt(); drv(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); check_eq("t7_no_stall", {16'h0, instr}, 32'h0430);

        repeat (3) nxt();
        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
